// File: rtl/masked_mul_scheduler.sv
// Round-robin scheduler sharing one external masked HPC3 multiplier; one fresh randomness word per op, 2-entry response FIFO.
// Issue at t, capture at t+1, response visible at t+2. Optional stats counters are enabled with MASKED_MUL_SCHED_STATS_EN.
module masked_mul_scheduler #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int NUM_QUAD   = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                                    in_clock,
    input  logic                                    in_reset,
    input  logic [NUM_REQ-1:0]                      in_req_valid,
    input  logic [NUM_REQ*NUM_SHARES*BIT_WIDTH-1:0] in_req_a,
    input  logic [NUM_REQ*NUM_SHARES*BIT_WIDTH-1:0] in_req_b,
    output logic [NUM_REQ-1:0]                      out_req_ready,
    input  logic                                    in_rand_valid,
    input  logic [2*NUM_QUAD*BIT_WIDTH-1:0]         in_rand,
    output logic                                    out_rand_ready,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]         out_mul_a,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]         out_mul_b,
    output logic [NUM_QUAD*BIT_WIDTH-1:0]           out_mul_r,
    output logic [NUM_QUAD*BIT_WIDTH-1:0]           out_mul_p,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0]         in_mul_c,
    output logic                                    out_resp_valid,
    output logic [ID_W-1:0]                         out_resp_id,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]         out_resp_c,
    input  logic                                    in_resp_ready
`ifdef MASKED_MUL_SCHED_STATS_EN
    ,
    output logic [31:0]                             out_stat_issued,
    output logic [31:0]                             out_stat_rand_stall
`endif
);
    localparam int OPW = NUM_SHARES * BIT_WIDTH;
    localparam int RW  = NUM_QUAD * BIT_WIDTH;

    logic            rand_full;
    logic [RW-1:0]   rand_r;
    logic [RW-1:0]   rand_p;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] inflight_id;
    logic            inflight;
    logic            grant_found;
    logic            room;
    logic            issue;
    logic            pop;
    logic            push;
    logic [1:0]      fifo_cnt;
    logic [ID_W-1:0] fifo_id [2];
    logic [OPW-1:0]  fifo_c  [2];

    always_comb begin : grant_search
        int idx;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_found && in_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Counting the in-flight op as occupied guarantees a FIFO slot when it lands next cycle.
    assign pop            = out_resp_valid && in_resp_ready;
    assign push           = inflight;
    assign room           = (int'(fifo_cnt) + int'(inflight) - int'(pop)) < 2;
    assign issue          = grant_found && rand_full && room;

    assign out_req_ready  = issue ? (NUM_REQ'(1) << grant_id) : '0;
    assign out_mul_a      = issue ? in_req_a[int'(grant_id)*OPW +: OPW] : '0;
    assign out_mul_b      = issue ? in_req_b[int'(grant_id)*OPW +: OPW] : '0;
    assign out_mul_r      = issue ? rand_r : '0;
    assign out_mul_p      = issue ? rand_p : '0;
    assign out_rand_ready = !rand_full || issue;

    assign out_resp_valid = (fifo_cnt != 2'd0);
    assign out_resp_id    = out_resp_valid ? fifo_id[0] : '0;
    assign out_resp_c     = out_resp_valid ? fifo_c[0]  : '0;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            rand_full <= 1'b0;
            rand_r    <= '0;
            rand_p    <= '0;
        end else if (in_rand_valid && out_rand_ready) begin
            rand_full <= 1'b1;
            rand_r    <= in_rand[RW-1:0];
            rand_p    <= in_rand[2*RW-1:RW];
        end else if (issue) begin
            rand_full <= 1'b0;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            inflight    <= 1'b0;
            inflight_id <= '0;
            rr_ptr      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_id <= grant_id;
                rr_ptr      <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Head always lives in entry 0 so the response outputs come straight from a register.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            fifo_cnt   <= 2'd0;
            fifo_id[0] <= '0;
            fifo_id[1] <= '0;
            fifo_c[0]  <= '0;
            fifo_c[1]  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        fifo_id[0] <= inflight_id;
                        fifo_c[0]  <= in_mul_c;
                    end else begin
                        fifo_id[1] <= inflight_id;
                        fifo_c[1]  <= in_mul_c;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_id[0] <= fifo_id[1];
                    fifo_c[0]  <= fifo_c[1];
                    fifo_cnt   <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_id[0] <= inflight_id;
                        fifo_c[0]  <= in_mul_c;
                    end else begin
                        fifo_id[0] <= fifo_id[1];
                        fifo_c[0]  <= fifo_c[1];
                        fifo_id[1] <= inflight_id;
                        fifo_c[1]  <= in_mul_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assert property (@(posedge in_clock) disable iff (!in_reset)
        !(push && !pop && fifo_cnt == 2'd2));

`ifdef MASKED_MUL_SCHED_STATS_EN
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            out_stat_issued     <= '0;
            out_stat_rand_stall <= '0;
        end else begin
            if (issue && out_stat_issued != 32'hFFFF_FFFF)
                out_stat_issued <= out_stat_issued + 32'd1;
            if ((|in_req_valid) && !rand_full && out_stat_rand_stall != 32'hFFFF_FFFF)
                out_stat_rand_stall <= out_stat_rand_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_masked_mul_scheduler.sv
// Directed bench for masked_mul_scheduler: queue-level reference model checked every cycle plus literal scenario checks.
module tb_masked_mul_scheduler;
    localparam int NR = 4;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] rnd;
    } op_t;

    typedef struct {
        int         id;
        logic [3:0] c;
    } rsp_t;

    logic          in_clock = 1'b0;
    logic          in_reset;
    logic [NR-1:0] in_req_valid;
    logic [15:0]   in_req_a;
    logic [15:0]   in_req_b;
    logic [NR-1:0] out_req_ready;
    logic          in_rand_valid;
    logic [3:0]    in_rand;
    logic          out_rand_ready;
    logic [3:0]    out_mul_a;
    logic [3:0]    out_mul_b;
    logic [1:0]    out_mul_r;
    logic [1:0]    out_mul_p;
    logic [3:0]    in_mul_c = 4'h0;
    logic          out_resp_valid;
    logic [1:0]    out_resp_id;
    logic [3:0]    out_resp_c;
    logic          in_resp_ready;
`ifdef MASKED_MUL_SCHED_STATS_EN
    logic [31:0]   out_stat_issued;
    logic [31:0]   out_stat_rand_stall;
`endif

    always #5 in_clock = ~in_clock;

    masked_mul_scheduler #(.NUM_SHARES(2), .BIT_WIDTH(2), .NUM_REQ(4)) dut (
        .in_clock(in_clock), .in_reset(in_reset),
        .in_req_valid(in_req_valid), .in_req_a(in_req_a), .in_req_b(in_req_b),
        .out_req_ready(out_req_ready),
        .in_rand_valid(in_rand_valid), .in_rand(in_rand), .out_rand_ready(out_rand_ready),
        .out_mul_a(out_mul_a), .out_mul_b(out_mul_b), .out_mul_r(out_mul_r), .out_mul_p(out_mul_p),
        .in_mul_c(in_mul_c),
        .out_resp_valid(out_resp_valid), .out_resp_id(out_resp_id), .out_resp_c(out_resp_c),
        .in_resp_ready(in_resp_ready)
`ifdef MASKED_MUL_SCHED_STATS_EN
        , .out_stat_issued(out_stat_issued), .out_stat_rand_stall(out_stat_rand_stall)
`endif
    );

    // GF(4) with x^2 + x + 1
    function automatic logic [1:0] gf4(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] xb;
        xb = {b[1] ^ b[0], b[1]};
        return (a[0] ? b : 2'b00) ^ (a[1] ? xb : 2'b00);
    endfunction

    // Stand-in multiplier: product re-masked with r, share0 = prod^r, share1 = r
    function automatic logic [3:0] mul_shares(input logic [3:0] a, input logic [3:0] b, input logic [1:0] r);
        logic [1:0] prod;
        prod = gf4(a[1:0] ^ a[3:2], b[1:0] ^ b[3:2]);
        return {r, prod ^ r};
    endfunction

    always @(posedge in_clock) in_mul_c <= mul_shares(out_mul_a, out_mul_b, out_mul_r);

    int         req_left [NR];
    logic [3:0] ra [NR];
    logic [3:0] rb [NR];
    logic [3:0] rand_val;
    logic       rand_en;
    logic       rst_drv;
    logic       rdy_drv;
    int         cyc = 0;

    int         m_ptr = 0;
    logic [3:0] m_rand_q [$];
    op_t        m_infl [$];
    rsp_t       m_fifo [$];

    int         g_id [$];
    int         g_cyc [$];
    logic [3:0] g_rp [$];
    int         r_id [$];
    int         r_cyc [$];
    logic [3:0] r_c [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        in_reset      = rst_drv;
        in_rand_valid = rand_en;
        in_rand       = rand_val;
        in_resp_ready = rdy_drv;
        for (int i = 0; i < NR; i++) begin
            in_req_valid[i]    = (req_left[i] > 0);
            in_req_a[i*4 +: 4] = ra[i];
            in_req_b[i*4 +: 4] = rb[i];
        end
    endtask

    task automatic step();
        logic       e_valid;
        int         e_id;
        logic [3:0] e_c;
        logic       pop;
        logic       any;
        logic       issue;
        logic       e_rr;
        int         g;
        int         idx;
        logic [3:0] rq;
        op_t        op;
        rsp_t       rs;
        drive();
        @(negedge in_clock);
        if (!in_reset) begin
            m_rand_q.delete();
            m_infl.delete();
            m_fifo.delete();
            m_ptr = 0;
        end
        e_valid = (m_fifo.size() > 0);
        e_id    = e_valid ? m_fifo[0].id : 0;
        e_c     = e_valid ? m_fifo[0].c : 4'h0;
        pop     = e_valid && in_resp_ready;
        any     = 1'b0;
        g       = 0;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!any && in_req_valid[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        issue = any && (m_rand_q.size() > 0) && ((m_fifo.size() + m_infl.size() - int'(pop)) < 2);
        e_rr  = (m_rand_q.size() == 0) || issue;
        rq    = (m_rand_q.size() > 0) ? m_rand_q[0] : 4'h0;

        chk("req_ready",  out_req_ready,  issue ? (4'b0001 << g) : 4'b0000);
        chk("mul_a",      out_mul_a,      issue ? ra[g] : 4'h0);
        chk("mul_b",      out_mul_b,      issue ? rb[g] : 4'h0);
        chk("mul_r",      out_mul_r,      issue ? rq[1:0] : 2'b00);
        chk("mul_p",      out_mul_p,      issue ? rq[3:2] : 2'b00);
        chk("rand_ready", out_rand_ready, e_rr);
        chk("resp_valid", out_resp_valid, e_valid);
        chk("resp_id",    out_resp_id,    e_id);
        chk("resp_c",     out_resp_c,     e_c);

        if (out_req_ready != 4'b0000) begin
            g_id.push_back(oh2i(out_req_ready));
            g_cyc.push_back(cyc);
            g_rp.push_back({out_mul_p, out_mul_r});
        end
        if (out_resp_valid && in_resp_ready) begin
            r_id.push_back(int'(out_resp_id));
            r_cyc.push_back(cyc);
            r_c.push_back(out_resp_c);
        end

        if (in_reset) begin
            if (pop) void'(m_fifo.pop_front());
            if (m_infl.size() > 0) begin
                op   = m_infl.pop_front();
                rs.id = op.id;
                rs.c  = mul_shares(op.a, op.b, op.rnd[1:0]);
                m_fifo.push_back(rs);
            end
            if (issue) begin
                op.id  = g;
                op.a   = ra[g];
                op.b   = rb[g];
                op.rnd = m_rand_q.pop_front();
                m_infl.push_back(op);
                m_ptr = (g + 1) % NR;
                req_left[g]--;
                ra[g] = ra[g] + 4'd5;
                rb[g] = rb[g] + 4'd3;
            end
            if (in_rand_valid && e_rr) begin
                m_rand_q.push_back(in_rand);
                rand_val = rand_val + 4'd1;
            end
        end
        @(posedge in_clock);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        run(2);
        rst_drv = 1'b1;
    endtask

    task automatic clear_logs();
        g_id.delete(); g_cyc.delete(); g_rp.delete();
        r_id.delete(); r_cyc.delete(); r_c.delete();
    endtask

    initial begin : main
        int         t0;
        int         t1;
        int         exp_order [5];
        logic [3:0] c0;
        rst_drv = 1'b0;
        rdy_drv = 1'b1;
        rand_en = 1'b0;
        rand_val = 4'h0;
        for (int i = 0; i < NR; i++) begin
            req_left[i] = 0;
            ra[i] = 4'h0;
            rb[i] = 4'h0;
        end
        run(2);
        chk("rst_rand_ready", out_rand_ready, 1'b1);
        chk("rst_resp_valid", out_resp_valid, 1'b0);
        chk("rst_req_ready",  out_req_ready,  4'b0000);
        rst_drv = 1'b1;

        // single op from requester 1, operand A is a masked zero
        clear_logs();
        req_left[1] = 1; ra[1] = 4'b0101; rb[1] = 4'b1110;
        rand_val = 4'h5; rand_en = 1'b1;
        t0 = cyc;
        run(6);
        chk("t1_ngrant", g_id.size(), 1);
        if (g_id.size() >= 1) begin
            chk("t1_gid",  g_id[0], 1);
            chk("t1_gcyc", g_cyc[0], t0 + 1);
            chk("t1_rp",   g_rp[0], 4'h5);
        end
        chk("t1_nresp", r_id.size(), 1);
        if (r_id.size() >= 1) begin
            c0 = r_c[0];
            chk("t1_rid",    r_id[0], 1);
            chk("t1_rcyc",   r_cyc[0], t0 + 3);
            chk("t1_unmask", c0[1:0] ^ c0[3:2], 2'b00);
        end

        // requesters 0 and 2 together from pointer 0
        do_reset();
        clear_logs();
        req_left[0] = 1; req_left[2] = 1;
        run(8);
        chk("t2_ngrant", g_id.size(), 2);
        if (g_id.size() >= 2) begin
            chk("t2_g0",  g_id[0], 0);
            chk("t2_g1",  g_id[1], 2);
            chk("t2_gap", g_cyc[1] - g_cyc[0], 1);
        end
        chk("t2_ptr", m_ptr, 3);
        chk("t2_nresp", r_id.size(), 2);
        if (r_id.size() >= 2) begin
            chk("t2_r0", r_id[0], 0);
            chk("t2_r1", r_id[1], 2);
        end

        // all four requesting, full throughput
        do_reset();
        clear_logs();
        exp_order = '{0, 1, 2, 3, 0};
        ra[0] = 4'b0110; rb[0] = 4'b1001;
        for (int i = 0; i < NR; i++) req_left[i] = 20;
        run(10);
        chk("t3_ngrant", g_id.size(), 9);
        if (g_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t3_order", g_id[i], exp_order[i]);
            chk("t3_gspan", g_cyc[4] - g_cyc[0], 4);
        end
        chk("t3_nresp", r_id.size(), 7);
        if (r_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t3_rorder", r_id[i], exp_order[i]);
            chk("t3_rspan", r_cyc[3] - r_cyc[0], 3);
            c0 = r_c[0];
            chk("t3_prod0", c0[1:0] ^ c0[3:2], 2'b10);
        end
        for (int i = 0; i < NR; i++) req_left[i] = 0;
        run(4);

        // randomness starvation
        do_reset();
        clear_logs();
        rand_en = 1'b0;
        req_left[3] = 1;
        run(4);
        chk("t4_nogrant", g_id.size(), 0);
        rand_en = 1'b1;
        t1 = cyc;
        run(4);
        chk("t4_ngrant", g_id.size(), 1);
        if (g_id.size() >= 1) begin
            chk("t4_gid",  g_id[0], 3);
            chk("t4_gcyc", g_cyc[0], t1 + 1);
        end
`ifdef MASKED_MUL_SCHED_STATS_EN
        chk("t4_stall",  out_stat_rand_stall, 32'd5);
        chk("t4_issued", out_stat_issued, 32'd1);
`endif

        // consumer backpressure
        clear_logs();
        rdy_drv = 1'b0;
        for (int i = 0; i < NR; i++) req_left[i] = 20;
        run(8);
        chk("t5_ngrant_blocked", g_id.size(), 2);
        chk("t5_valid_held", out_resp_valid, 1'b1);
        rdy_drv = 1'b1;
        run(10);
        chk("t5_resume", g_id.size() > 2, 1'b1);
        if (r_id.size() >= 2) begin
            chk("t5_r0", r_id[0], 0);
            chk("t5_r1", r_id[1], 1);
        end
        for (int i = 0; i < r_id.size() && i < g_id.size(); i++) chk("t5_inorder", r_id[i], g_id[i]);
        for (int i = 0; i < NR; i++) req_left[i] = 0;
        run(4);

        // reset one cycle after an issue
        clear_logs();
        rand_en = 1'b0;
        req_left[2] = 1;
        for (int i = 0; i < 4 && g_id.size() == 0; i++) step();
        chk("t6_issued", g_id.size(), 1);
        rst_drv = 1'b0;
        run(1);
        rst_drv = 1'b1;
        run(4);
        chk("t6_noresp", r_id.size(), 0);
        chk("t6_resp_valid", out_resp_valid, 1'b0);
        chk("t6_rand_ready", out_rand_ready, 1'b1);
        chk("t6_ptr", m_ptr, 0);
        req_left[0] = 1; req_left[3] = 1;
        rand_en = 1'b1;
        run(6);
        chk("t6_ngrant", g_id.size(), 3);
        if (g_id.size() >= 3) begin
            chk("t6_first_after_rst", g_id[1], 0);
            chk("t6_second_after_rst", g_id[2], 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/masked_mul_scheduler.md
Name: masked_mul_scheduler

Overview:
- Shares one masked HPC3 multiplier instance between NUM_REQ requesters, e.g. S-box inversion stages or the key-schedule S-box.
- Round-robin arbitration; consumes exactly one fresh randomness word per issued multiplication.
- Tracks the single in-flight operation and returns each result with its requester ID through a 2-entry response FIFO.
- The multiplier is instantiated outside this block; the scheduler drives its operand/randomness inputs and samples its output.

Parameters:
NUM_SHARES, 2, number of Boolean shares per operand
BIT_WIDTH, 2, bit width of one share (field element)
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), requester ID width (derived)
NUM_QUAD, num_quad(NUM_SHARES), randomness elements per r/p vector (derived, from aes128_package)

Ports:
in_clock  input  1  clock
in_reset  input  1  reset, asynchronous, active-low
in_req_valid  input  NUM_REQ  request valid per requester
in_req_a  input  NUM_REQ*NUM_SHARES*BIT_WIDTH  shared operand A per requester
in_req_b  input  NUM_REQ*NUM_SHARES*BIT_WIDTH  shared operand B per requester
out_req_ready  output  NUM_REQ  one-hot grant; transfer when valid&ready
in_rand_valid  input  1  randomness word valid
in_rand  input  2*NUM_QUAD*BIT_WIDTH  fresh randomness; low half = r, high half = p
out_rand_ready  output  1  randomness accepted when valid&ready
out_mul_a  output  NUM_SHARES*BIT_WIDTH  to multiplier in_a
out_mul_b  output  NUM_SHARES*BIT_WIDTH  to multiplier in_b
out_mul_r  output  NUM_QUAD*BIT_WIDTH  to multiplier in_r
out_mul_p  output  NUM_QUAD*BIT_WIDTH  to multiplier in_p
in_mul_c  input  NUM_SHARES*BIT_WIDTH  from multiplier out_c
out_resp_valid  output  1  response FIFO head valid
out_resp_id  output  ID_W  requester ID of head
out_resp_c  output  NUM_SHARES*BIT_WIDTH  product shares of head
in_resp_ready  input  1  consumer pops head when valid&ready

Behaviour:
- Reset (in_reset low, async): rand buffer empty, RR pointer=0, inflight=0, FIFO empty. All outputs 0, except out_rand_ready=1.
- Rand buffer: 1 entry. out_rand_ready = !rand_full || issue. Load on valid&ready. A load and an issue in the same cycle replace the consumed entry.
- Issue condition at cycle t: any in_req_valid, rand_full, and (fifo_count + inflight - pop) < 2, where pop = out_resp_valid & in_resp_ready.
- Grant: first valid requester at or after the RR pointer, wrapping modulo NUM_REQ. On issue, pointer <= granted+1 (wrap). Pointer holds when there is no issue.
- out_req_ready has exactly one bit set, for the granted requester, and only in the issue cycle. A requester must hold valid and data until granted.
- Issue cycle: out_mul_a/b = granted operands; out_mul_r/p = rand buffer. The buffer is consumed.
- Non-issue cycles: all out_mul_* = 0. Randomness is never reused.
- Latency: issue at t. in_mul_c is valid in cycle t+1 and is pushed into the FIFO at the end of t+1 together with the ID latched at t. The response is visible at t+2 at the earliest.
- inflight is set on issue and cleared after capture. Issue and capture in the same cycle keep inflight=1. Sustained throughput is 1 op/cycle when in_resp_ready=1.
- FIFO: 2 entries, first-word fall-through registered head. Push and pop in the same cycle are allowed when full. Overflow cannot occur by construction; flag it with an assertion.
- Responses return in issue order.
- Reset mid-operation discards the in-flight op, the buffered randomness and FIFO contents. Requesters must re-request.

Optional Feature:
- MASKED_MUL_SCHED_STATS_EN defined: adds out_stat_issued (32b, counts issues) and out_stat_rand_stall (32b, counts cycles with a request valid but rand buffer empty). Both are saturating and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- NUM_SHARES=2, BIT_WIDTH=2. Requester 1 issues a=shares{01,01} (value 0), b=any, rand=0x5 valid -> out_req_ready=4'b0010 in the issue cycle. Response 2 cycles later with id=1 and c0^c1=00.
- Requesters 0 and 2 request simultaneously, pointer=0 -> grants 0 then 2 on consecutive cycles. Pointer ends at 3. Responses id 0 then 2.
- All 4 requesters hold valid, rand always valid, resp_ready=1 -> grant order 0,1,2,3,0. One response per cycle. Unmasked products match the generic_mul golden model.
- in_rand_valid=0 while a request is pending -> no grant, out_mul_*=0. Stats stall counter increments each cycle. The first cycle rand becomes valid, issue occurs the following cycle.
- in_resp_ready=0 with a continuous request stream -> exactly 2 responses buffered, no further grants. On ready=1, drain in order and issuing resumes.
- Assert in_reset low one cycle after an issue -> out_resp_valid stays 0 after release. Pointer=0, out_rand_ready=1.
